// File: rtl/dmux_1by8_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dmux_1by8_scheduler_if
// Description : Upstream word handshake, eight-channel downstream handshake
//               and status bundle for the 1-to-8 demux scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmux_1by8_scheduler_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_dest;
  logic         mode;
  logic [7:0]   en_mask;
  logic [2:0]   s;
  logic [7:0]   y_valid;
  logic [W-1:0] y_data;
  logic [7:0]   y_ready;
  logic         drop;
  logic [15:0]  xfer_cnt;

  // Environment side: produces upstream words and downstream accepts.
  modport master (
    output in_valid, in_data, in_dest, mode, en_mask, y_ready,
    input  in_ready, s, y_valid, y_data, drop, xfer_cnt
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, in_dest, mode, en_mask, y_ready,
    output in_ready, s, y_valid, y_data, drop, xfer_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dmux_1by8_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dmux_1by8_scheduler
// Description : Accepts one word at a time and steers it to one of eight
//               channels, either by explicit destination or round-robin over
//               enabled channels; holds the word until that channel accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_1by8_scheduler (
  input  wire logic                clk,
  input  wire logic                rst_n,
  dmux_1by8_scheduler_if.slave     bus
);
  localparam int W = $bits(bus.in_data);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   s_q, s_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [7:0]   y_valid_q, y_valid_d;
  logic [W-1:0] y_data_q, y_data_d;
  logic         drop_q, drop_d;
  logic [15:0]  xfer_cnt_q, xfer_cnt_d;

  logic         in_ready;
  logic [2:0]   rr_target;
  logic         rr_found;
  logic [2:0]   rr_idx;

  // Round-robin pick: first enabled channel after ptr, ptr itself checked last.
  always_comb begin
    rr_found  = 1'b0;
    rr_target = ptr_q;
    rr_idx    = ptr_q;
    for (int i = 1; i <= 8; i++) begin
      rr_idx = ptr_q + 3'(i);
      if (!rr_found && bus.en_mask[rr_idx]) begin
        rr_found  = 1'b1;
        rr_target = rr_idx;
      end
    end
  end

  // Next-state and handshake logic for the IDLE/DRIVE controller.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    ptr_d      = ptr_q;
    y_valid_d  = y_valid_q;
    y_data_d   = y_data_q;
    drop_d     = 1'b0;
    xfer_cnt_d = xfer_cnt_q;
    in_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        // Round-robin with nothing enabled has nowhere to send a word.
        in_ready = bus.mode ? rr_found : 1'b1;
        if (bus.in_valid && in_ready) begin
          y_data_d = bus.in_data;
          if (bus.mode) begin
            s_d       = rr_target;
            y_valid_d = 8'b1 << rr_target;
            state_d   = DRIVE;
          end else if (bus.en_mask[bus.in_dest]) begin
            s_d       = bus.in_dest;
            y_valid_d = 8'b1 << bus.in_dest;
            state_d   = DRIVE;
          end else begin
            // Addressed to a disabled channel: consume and discard.
            drop_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (bus.y_ready[s_q]) begin
          ptr_d      = s_q;
          xfer_cnt_d = xfer_cnt_q + 16'd1;
          y_valid_d  = 8'h00;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; ptr resets to 7 so the first round-robin pick is channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= 3'd0;
      ptr_q      <= 3'd7;
      y_valid_q  <= 8'h00;
      y_data_q   <= '0;
      drop_q     <= 1'b0;
      xfer_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      ptr_q      <= ptr_d;
      y_valid_q  <= y_valid_d;
      y_data_q   <= y_data_d;
      drop_q     <= drop_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.s        = s_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.y_data   = y_data_q;
  assign bus.drop     = drop_q;
  assign bus.xfer_cnt = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmux_1by8_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux_1by8_scheduler
// Description : Self-checking bench for dmux_1by8_scheduler: vector table
//               with a delivery scoreboard plus hand-written corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux_1by8_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  dmux_1by8_scheduler_if #(.W(8)) bus ();

  dmux_1by8_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       md;
    logic [2:0] dest;
    logic [7:0] mask;
    logic [7:0] data;
    logic [2:0] exp_ch;
    logic       exp_drop;
  } vec_t;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
  } sb_t;

  sb_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a completion is due whenever the selected channel accepts.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.y_valid != 8'h00) begin
      check("y_valid_onehot", {24'd0, bus.y_valid}, {24'd0, 8'b1 << bus.s});
      if (bus.y_ready[bus.s]) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_delivery: channel %0d data 0x%0h with empty scoreboard", bus.s, bus.y_data);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("deliver_ch", {29'd0, bus.s}, {29'd0, e.ch});
          check("deliver_data", {24'd0, bus.y_data}, {24'd0, e.data});
        end
      end
    end
  end

  // Present one word from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic md, input logic [2:0] dest, input logic [7:0] mask,
                      input logic [7:0] data, input logic push, input logic [2:0] exp_ch,
                      output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    bus.mode = md; bus.in_dest = dest; bus.en_mask = mask; bus.in_data = data;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1;
        acc_cyc = cyc;
        if (push) sb.push_back('{ch: exp_ch, data: data});
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: in_ready never rose for data 0x%0h", data);
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  vec_t vt[16];
  int   acc[16];
  int   ac;

  initial begin
    // Round-robin over all channels from reset: 0..7 then wrap to 0,1 (ptr ends at 1).
    for (int i = 0; i < 10; i++)
      vt[i] = '{md: 1'b1, dest: 3'd0, mask: 8'hFF, data: 8'(8'h10 + i), exp_ch: 3'(i % 8), exp_drop: 1'b0};
    // Two enabled channels from ptr=1: 2,5,2,5.
    vt[10] = '{1'b1, 3'd0, 8'h24, 8'hA0, 3'd2, 1'b0};
    vt[11] = '{1'b1, 3'd0, 8'h24, 8'hA1, 3'd5, 1'b0};
    vt[12] = '{1'b1, 3'd0, 8'h24, 8'hA2, 3'd2, 1'b0};
    vt[13] = '{1'b1, 3'd0, 8'h24, 8'hA3, 3'd5, 1'b0};
    // Addressed to disabled channel 3 is dropped; channel 4 is then delivered.
    vt[14] = '{1'b0, 3'd3, 8'hF7, 8'hB3, 3'd3, 1'b1};
    vt[15] = '{1'b0, 3'd4, 8'hF7, 8'hB4, 3'd4, 1'b0};

    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_dest = 3'd0;
    bus.mode = 1'b1; bus.en_mask = 8'hFF; bus.y_ready = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_s", {29'd0, bus.s}, 32'd0);
    check("rst_y_valid", {24'd0, bus.y_valid}, 32'd0);
    check("rst_y_data", {24'd0, bus.y_data}, 32'd0);
    check("rst_drop", {31'd0, bus.drop}, 32'd0);
    check("rst_xfer_cnt", {16'd0, bus.xfer_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      send(vt[i].md, vt[i].dest, vt[i].mask, vt[i].data, !vt[i].exp_drop, vt[i].exp_ch, acc[i]);
      check($sformatf("drop_v%0d", i), {31'd0, bus.drop}, {31'd0, vt[i].exp_drop});
      if (vt[i].exp_drop)
        check("drop_no_valid", {24'd0, bus.y_valid}, 32'd0);
    end
    check("b2b_10_words_cycles", 32'(acc[9] - acc[0]), 32'd18);
    @(negedge clk); @(negedge clk);
    check("xfer_cnt_after_table", {16'd0, bus.xfer_cnt}, 32'd15);
    check("drop_one_cycle", {31'd0, bus.drop}, 32'd0);

    // Round-robin with nothing enabled never accepts.
    bus.mode = 1'b1; bus.en_mask = 8'h00; bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rr_mask0_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rr_mask0_no_valid", {24'd0, bus.y_valid}, 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("rr_mask0_cnt", {16'd0, bus.xfer_cnt}, 32'd15);

    // Stall on channel 6 for five cycles while other channels are ready.
    bus.y_ready = 8'hBF;
    send(1'b0, 3'd6, 8'hFF, 8'h66, 1'b1, 3'd6, ac);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_y_valid", {24'd0, bus.y_valid}, 32'h40);
      check("stall_y_data", {24'd0, bus.y_data}, 32'h66);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus.y_ready = 8'hFF;
    @(negedge clk);
    #1;
    check("stall_done_valid", {24'd0, bus.y_valid}, 32'd0);
    check("stall_done_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("stall_done_cnt", {16'd0, bus.xfer_cnt}, 32'd16);
    @(negedge clk);

    // Mid-DRIVE: disable channel 1 and flip mode; delivery to 1 still completes.
    bus.y_ready = 8'h00;
    send(1'b0, 3'd1, 8'hFF, 8'h77, 1'b1, 3'd1, ac);
    bus.en_mask = 8'hFD; bus.mode = 1'b1;
    @(negedge clk);
    #1;
    check("mid_hold_valid", {24'd0, bus.y_valid}, 32'h02);
    bus.y_ready = 8'hFF;
    @(negedge clk);
    #1;
    check("mid_done_cnt", {16'd0, bus.xfer_cnt}, 32'd17);
    @(negedge clk);
    // New settings from ptr=1: channel 2.
    send(1'b1, 3'd0, 8'hFD, 8'h78, 1'b1, 3'd2, ac);
    @(negedge clk);

    // Asynchronous reset while driving a word.
    bus.y_ready = 8'h00;
    send(1'b1, 3'd0, 8'hFF, 8'h99, 1'b1, 3'd3, ac);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_y_valid", {24'd0, bus.y_valid}, 32'd0);
    check("arst_s", {29'd0, bus.s}, 32'd0);
    check("arst_cnt", {16'd0, bus.xfer_cnt}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.y_ready = 8'hFF;
    @(negedge clk);
    send(1'b1, 3'd0, 8'hFF, 8'h5A, 1'b1, 3'd0, ac);
    #1;
    check("post_rst_s", {29'd0, bus.s}, 32'd0);
    @(negedge clk); @(negedge clk);
    check("post_rst_cnt", {16'd0, bus.xfer_cnt}, 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dmux_1by8_scheduler.md
# dmux_1by8_scheduler

Sequencing controller for the 1-to-8 demultiplexer datapath. It accepts words from one upstream source over a valid/ready handshake and selects one of eight downstream channels, either from an explicit destination field (addressed mode) or by round-robin over enabled channels. It then holds the word on the selected channel until that channel accepts it. It drives the 3-bit select `s` consumed by the demux tree and provides per-channel valid/ready handshakes.

## Interface
- `W`, default 8: data word width.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  upstream word available.
- `in_ready`  output  1  block can accept a word this cycle.
- `in_data`  input  W  upstream word.
- `in_dest`  input  3  destination channel, used in addressed mode only.
- `mode`  input  1  0 = addressed, 1 = round-robin; sampled at acceptance.
- `en_mask`  input  8  per-channel enable; sampled at acceptance.
- `s`  output  3  current demux select (channel index).
- `y_valid`  output  8  one-hot per-channel valid; at most one bit high.
- `y_data`  output  W  word presented to the selected channel.
- `y_ready`  input  8  per-channel accept.
- `drop`  output  1  one-cycle pulse when an addressed word targets a disabled channel.
- `xfer_cnt`  output  16  count of completed deliveries, wraps 0xFFFF -> 0.

## Operation
- FSM states: IDLE, DRIVE.
- IDLE:
  - Addressed mode: `in_ready`=1.
  - Round-robin mode: `in_ready`=1 only if `en_mask`!=0.
  - On `in_valid & in_ready`, latch `in_data` and compute the target channel.
- Addressed mode:
  - target = `in_dest`.
  - If `en_mask[in_dest]`=0, the word is consumed and discarded. `drop` pulses for one cycle, the state stays IDLE, and `ptr` and `xfer_cnt` are unchanged.
- Round-robin mode:
  - target = first channel with `en_mask` bit set, searching ptr+1, ptr+2, … with wrap mod 8. `ptr` itself is the last candidate.
- Valid target: `s` <= target, go to DRIVE.
- DRIVE:
  - `y_valid[s]`=1, `y_data`=latched word, `in_ready`=0.
  - On `y_ready[s]`=1: transfer completes, `ptr` <= `s` (both modes), `xfer_cnt` += 1, go to IDLE.
  - `y_ready` bits of other channels are ignored.
- `mode` and `en_mask` changes while in DRIVE do not affect the transfer in flight. A channel disabled mid-DRIVE still completes.
- `s` holds its last value in IDLE. `y_data` holds the last latched word. `y_valid` is all-zero in IDLE.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - state=IDLE, `s`=0, `ptr`=7, `y_valid`=0, `y_data`=0, `drop`=0, `xfer_cnt`=0.
  - `in_ready` follows IDLE rules.
- Accept at edge T: `y_valid[target]`=1 and `s`=target from T+1.
- Completion at edge C (`y_ready[s]` high before C): `y_valid`=0 and `in_ready` high from C+1.
- Minimum 2 cycles per word (one-cycle IDLE bubble); no bypass.
- `drop` is asserted in the cycle after the accepting edge.
- `in_ready` is a registered-state function plus combinational `mode`/`en_mask` in IDLE. `y_valid`/`s`/`y_data` are registered.
- `rst_n` low mid-DRIVE: the word is lost, outputs go to reset values immediately, and no completion is counted.
- Round-robin with a single enabled channel k: every word goes to k. Wrap from 7 to 0 is exercised by `ptr`=7 at reset.

## Test plan
- Reset release, round-robin, `en_mask`=0xFF, `y_ready`=0xFF, 10 back-to-back words -> channels 0,1,…,7,0,1 in order, one word per 2 cycles, `xfer_cnt`=10.
- Round-robin, `en_mask`=0x24 -> deliveries alternate channel 2, 5, 2, 5. Then `en_mask`=0x00 -> `in_ready`=0 and no acceptance.
- Addressed, `in_dest`=6 with `y_ready[6]` held low 5 cycles (other `y_ready` bits high) -> `y_valid`=0x40 held, `y_data` stable, `in_ready`=0 for the whole stall, completion on the cycle `y_ready[6]` rises.
- Addressed, `in_dest`=3 with `en_mask`=0xF7 -> word accepted, `drop` one-cycle pulse, no `y_valid`, `xfer_cnt` unchanged. Next word to `in_dest`=4 is delivered normally.
- Mid-DRIVE change: start a transfer to channel 1, clear `en_mask[1]` and flip `mode` before `y_ready[1]` -> delivery to 1 completes. The next pick uses the new settings with `ptr`=1.
- Assert `rst_n`=0 during DRIVE -> `y_valid`=0 and `s`=0 asynchronously, `xfer_cnt`=0. After release, round-robin starts again at channel 0.
